// File: rtl/led_fb_arbiter_if.sv
// Signal bundle between led_fb_arbiter (slave side) and its environment (master side):
// driver read port, host write/swap port and the single-port frame-buffer RAM port.
interface led_fb_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int PIX_WIDTH  = 24
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [PIX_WIDTH-1:0]  rd_data;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [PIX_WIDTH-1:0]  wr_data;
    logic                  wr_gnt;

    logic                  swap_req;
    logic                  frame_done;
    logic                  swap_ack;
    logic                  front_bank;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH:0]   mem_addr;
    logic [PIX_WIDTH-1:0]  mem_wdata;
    logic [PIX_WIDTH-1:0]  mem_rdata;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_done, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, swap_ack, front_bank,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_done, mem_rdata,
        output rd_gnt, rd_valid, rd_data, wr_gnt, swap_ack, front_bank,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/led_fb_arbiter.sv
// Double-buffered LED frame-buffer arbiter: one shared single-port RAM, driver reads the
// front bank, host writes the back bank. Define LED_FB_STARVE_GUARD_EN for write anti-starvation.
module led_fb_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int PIX_WIDTH    = 24,
    parameter int STARVE_LIMIT = 8
) (
    input logic             clk,
    input logic             rst,
    led_fb_arbiter_if.slave bus
);
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  force_wr;
    logic                  swap_fire;

    logic                  mem_en_q,       mem_en_d;
    logic                  mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH:0]   mem_addr_q,     mem_addr_d;
    logic [PIX_WIDTH-1:0]  mem_wdata_q,    mem_wdata_d;
    logic                  rd_pend_q,      rd_pend_d;
    logic                  rd_valid_q,     rd_valid_d;
    logic [PIX_WIDTH-1:0]  rd_hold_q,      rd_hold_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  swap_ack_q,     swap_ack_d;
    logic                  front_bank_q,   front_bank_d;

`ifdef LED_FB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Reads granted back-to-back while a write waits; at the limit the write wins once.
    assign force_wr = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.wr_req || wr_gnt) begin
            starve_cnt_d = '0;
        end else if (rd_gnt) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict read priority; STARVE_LIMIT only has an effect with the guard built in.
    assign force_wr = 1'b0 & (STARVE_LIMIT != 0);
`endif

    assign wr_gnt = !rst && bus.wr_req && (!bus.rd_req || force_wr);
    assign rd_gnt = !rst && bus.rd_req && !wr_gnt;

    always_comb begin
        mem_en_d    = rd_gnt | wr_gnt;
        mem_we_d    = wr_gnt;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_gnt) begin
            mem_addr_d = {front_bank_q, bus.rd_addr};
        end else if (wr_gnt) begin
            mem_addr_d  = {~front_bank_q, bus.wr_addr};
            mem_wdata_d = bus.wr_data;
        end

        // RAM answers one cycle after mem_en, so valid trails the grant by two cycles.
        rd_pend_d  = rd_gnt;
        rd_valid_d = rd_pend_q;
        rd_hold_d  = rd_valid_q ? bus.mem_rdata : rd_hold_q;

        swap_fire      = bus.frame_done && (swap_pending_q || bus.swap_req);
        front_bank_d   = front_bank_q ^ swap_fire;
        swap_ack_d     = swap_fire;
        swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q | bus.swap_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rd_pend_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_hold_q      <= '0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            front_bank_q   <= 1'b0;
        end else begin
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_pend_q      <= rd_pend_d;
            rd_valid_q     <= rd_valid_d;
            rd_hold_q      <= rd_hold_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            front_bank_q   <= front_bank_d;
        end
    end

    // Read data is presented straight from the RAM in the valid cycle, then held.
    assign bus.rd_data    = rd_valid_q ? bus.mem_rdata : rd_hold_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_gnt     = rd_gnt;
    assign bus.wr_gnt     = wr_gnt;
    assign bus.swap_ack   = swap_ack_q;
    assign bus.front_bank = front_bank_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_led_fb_arbiter.sv
// Self-checking bench for led_fb_arbiter: directed vector table, hand sequences for
// contention/reset, then random traffic against a frame-buffer reference model.
module tb_led_fb_arbiter;
    localparam int AW    = 11;
    localparam int PW    = 24;
    localparam int LIMIT = 8;
    localparam int DEPTH = 1 << (AW + 1);
`ifdef LED_FB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_fb_arbiter_if #(.ADDR_WIDTH(AW), .PIX_WIDTH(PW)) bus ();

    led_fb_arbiter #(.ADDR_WIDTH(AW), .PIX_WIDTH(PW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [PW-1:0] initPix(input int a);
        if (a == 5) return 24'hFF0000;
        return PW'((a * 32'h9E37) ^ 32'h5A5A5A);
    endfunction

    // Environment RAM: single port, one-cycle read latency, unwritten words hold initPix.
    logic [PW-1:0] ram [DEPTH];
    bit            ram_written [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]         <= bus.mem_wdata;
                ram_written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_written[bus.mem_addr] ? ram[bus.mem_addr]
                                                           : initPix(int'(bus.mem_addr));
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: displayed bank, swap bookkeeping, expected RAM port and reads.
    typedef struct {
        int            due;
        logic [PW-1:0] data;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    logic [PW-1:0] m_shadow [DEPTH];
    bit            m_shadow_wr [DEPTH];
    logic          m_front = 1'b0, m_pending = 1'b0, m_ack = 1'b0;
    logic          m_mem_en = 1'b0, m_mem_we = 1'b0;
    logic [AW:0]   m_mem_addr = '0;
    logic [PW-1:0] m_mem_wdata = '0, m_last_rd = '0;
    int            m_starve = 0;
    logic          e_rd_gnt, e_wr_gnt;

    typedef struct {
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic [PW-1:0] wr_data;
        logic          swap_req;
        logic          frame_done;
        logic          e_rd_gnt;
        logic          e_wr_gnt;
        logic          e_mem_en;
        logic          e_mem_we;
        logic [AW:0]   e_mem_addr;
        logic          e_rd_valid;
        logic [PW-1:0] e_rd_data;
        logic          e_front;
        logic          e_ack;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rr, input logic [AW-1:0] ra,
                                 input logic wr, input logic [AW-1:0] wa, input logic [PW-1:0] wd,
                                 input logic sw, input logic fd);
        rst            = r;
        bus.rd_req     = rr;
        bus.rd_addr    = ra;
        bus.wr_req     = wr;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.swap_req   = sw;
        bus.frame_done = fd;
    endtask

    function automatic logic [PW-1:0] shadowRead(input logic [AW:0] a);
        return m_shadow_wr[a] ? m_shadow[a] : initPix(int'(a));
    endfunction

    task automatic checkOutput();
        logic          exp_valid;
        logic [PW-1:0] exp_data;
        e_wr_gnt = !rst && bus.wr_req && (!bus.rd_req || (GUARD && m_starve >= LIMIT));
        e_rd_gnt = !rst && bus.rd_req && !e_wr_gnt;
        check("rd_gnt", 32'(bus.rd_gnt), 32'(e_rd_gnt));
        check("wr_gnt", 32'(bus.wr_gnt), 32'(e_wr_gnt));
        check("gnt_exclusive", 32'(bus.rd_gnt & bus.wr_gnt), 32'(0));
        check("mem_en", 32'(bus.mem_en), 32'(m_mem_en));
        if (m_mem_en) begin
            check("mem_we", 32'(bus.mem_we), 32'(m_mem_we));
            check("mem_addr", 32'(bus.mem_addr), 32'(m_mem_addr));
            if (m_mem_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_mem_wdata));
        end
        exp_valid = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        exp_data  = exp_valid ? rd_q[0].data : m_last_rd;
        if (exp_valid) begin
            m_last_rd = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
        check("rd_data", 32'(bus.rd_data), 32'(exp_data));
        check("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
        check("front_bank", 32'(bus.front_bank), 32'(m_front));
    endtask

    task automatic advanceModel();
        logic [AW:0] a;
        logic        fire;
        rd_exp_t     e;
        if (rst) begin
            m_front = 1'b0; m_pending = 1'b0; m_ack = 1'b0; m_starve = 0;
            m_mem_en = 1'b0; m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0;
            m_last_rd = '0;
            rd_q.delete();
        end else begin
            m_mem_en = e_rd_gnt || e_wr_gnt;
            m_mem_we = e_wr_gnt;
            if (e_rd_gnt) begin
                a          = {m_front, bus.rd_addr};
                m_mem_addr = a;
                e.due      = cyc + 2;
                e.data     = shadowRead(a);
                rd_q.push_back(e);
            end else if (e_wr_gnt) begin
                a              = {~m_front, bus.wr_addr};
                m_mem_addr     = a;
                m_mem_wdata    = bus.wr_data;
                m_shadow[a]    = bus.wr_data;
                m_shadow_wr[a] = 1'b1;
            end
            if (!bus.wr_req || e_wr_gnt) m_starve = 0;
            else if (e_rd_gnt)           m_starve++;
            fire  = bus.frame_done && (m_pending || bus.swap_req);
            m_ack = fire;
            if (fire) begin
                m_front   = ~m_front;
                m_pending = 1'b0;
            end else if (bus.swap_req) begin
                m_pending = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic finishCycle();
        checkOutput();
        advanceModel();
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        finishCycle();
    endtask

    task automatic idle(input logic r);
        applyStimulus(r, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // rd, addr, wr, waddr, wdata, swap, fd | rgnt, wgnt, en, we, maddr, valid, rdata, front, ack
        vecs[0]  = '{1'b1, 11'h005, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'h000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h005, 1'b0, 24'h000000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 11'h000, 1'b1, 11'h010, 24'h00FF00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 24'hFF0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h810, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 11'h010, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'hFF0000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h810, 1'b0, 24'hFF0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 24'h00FF00, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'h00FF00, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'h00FF00, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'h00FF00, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 11'h000, 1'b0, 11'h000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 24'h00FF00, 1'b0, 1'b0};

        idle(1'b1);
        @(posedge clk);
        #1;
        // Grants must stay low during reset even with both requests up.
        applyStimulus(1'b1, 1'b1, 11'h001, 1'b1, 11'h002, 24'h123456, 1'b0, 1'b0);
        stepCycle();

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, vecs[i].rd_req, vecs[i].rd_addr, vecs[i].wr_req, vecs[i].wr_addr,
                          vecs[i].wr_data, vecs[i].swap_req, vecs[i].frame_done);
            @(negedge clk);
            check("vec rd_gnt", 32'(bus.rd_gnt), 32'(vecs[i].e_rd_gnt));
            check("vec wr_gnt", 32'(bus.wr_gnt), 32'(vecs[i].e_wr_gnt));
            check("vec mem_en", 32'(bus.mem_en), 32'(vecs[i].e_mem_en));
            if (vecs[i].e_mem_en) begin
                check("vec mem_we", 32'(bus.mem_we), 32'(vecs[i].e_mem_we));
                check("vec mem_addr", 32'(bus.mem_addr), 32'(vecs[i].e_mem_addr));
            end
            check("vec rd_valid", 32'(bus.rd_valid), 32'(vecs[i].e_rd_valid));
            check("vec rd_data", 32'(bus.rd_data), 32'(vecs[i].e_rd_data));
            check("vec front_bank", 32'(bus.front_bank), 32'(vecs[i].e_front));
            check("vec swap_ack", 32'(bus.swap_ack), 32'(vecs[i].e_ack));
            finishCycle();
        end

        $display("[TB] read/write contention");
        for (int i = 0; i < 20; i++) begin
            logic exp_w;
            applyStimulus(1'b0, 1'b1, AW'($urandom), 1'b1, AW'($urandom), PW'($urandom), 1'b0, 1'b0);
            exp_w = GUARD ? (i % 9 == 8) : 1'b0;
            @(negedge clk);
            check("contention wr_gnt", 32'(bus.wr_gnt), 32'(exp_w));
            check("contention rd_gnt", 32'(bus.rd_gnt), 32'(!exp_w));
            finishCycle();
        end
        idle(1'b0);
        stepCycle();
        stepCycle();

        $display("[TB] reset in the middle of a read");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        stepCycle();
        idle(1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 11'h123, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("midrst front_before", 32'(bus.front_bank), 32'(1));
        check("midrst rd_gnt", 32'(bus.rd_gnt), 32'(1));
        finishCycle();
        idle(1'b1);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            @(negedge clk);
            check("midrst rd_valid", 32'(bus.rd_valid), 32'(0));
            check("midrst mem_en", 32'(bus.mem_en), 32'(0));
            check("midrst mem_addr", 32'(bus.mem_addr), 32'(0));
            check("midrst mem_wdata", 32'(bus.mem_wdata), 32'(0));
            check("midrst rd_data", 32'(bus.rd_data), 32'(0));
            check("midrst swap_ack", 32'(bus.swap_ack), 32'(0));
            check("midrst front_bank", 32'(bus.front_bank), 32'(0));
            finishCycle();
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic          r, rr, wr, sw, fd;
            logic [AW-1:0] ra, wa;
            r  = ($urandom_range(0, 99) == 0);
            rr = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
            wr = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) != 0);
            sw = ($urandom_range(0, 9) == 0);
            fd = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            applyStimulus(r, rr, ra, wr, wa, PW'($urandom), sw, fd);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_fb_arbiter.md
LED_FB_ARBITER -- requirements
Module: led_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, pixel address width per bank (64x32 panel).
REQ-002 SHALL have parameter PIX_WIDTH, default 24, pixel word width (8-bit R,G,B).
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, consecutive read grants tolerated while a write waits.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rd_req  input  1  driver read request, held until rd_gnt.
REQ-007 SHALL have port rd_addr  input  ADDR_WIDTH  driver pixel address, stable while rd_req high.
REQ-008 SHALL have port rd_gnt  output  1  read accepted this cycle (combinational).
REQ-009 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse per granted read.
REQ-010 SHALL have port rd_data  output  PIX_WIDTH  read pixel.
REQ-011 SHALL have port wr_req  input  1  host write request, held until wr_gnt.
REQ-012 SHALL have ports wr_addr  input  ADDR_WIDTH and wr_data  input  PIX_WIDTH  host write address/data.
REQ-013 SHALL have port wr_gnt  output  1  write accepted this cycle (combinational).
REQ-014 SHALL have ports swap_req  input  1  host bank-swap pulse; frame_done  input  1  driver end-of-frame pulse; swap_ack  output  1  swap applied pulse.
REQ-015 SHALL have port front_bank  output  1  bank currently displayed.
REQ-016 SHALL have ports mem_en, mem_we  output  1; mem_addr  output  ADDR_WIDTH+1; mem_wdata  output  PIX_WIDTH; mem_rdata  input  PIX_WIDTH (single-port RAM, 1-cycle read latency).

Function
REQ-017 SHALL grant at most one requester per cycle; rd_gnt and wr_gnt never both high.
REQ-018 SHALL, by default, grant read when rd_req high, else write when wr_req high.
REQ-019 SHALL, on a grant in cycle T, register mem_en=1, mem_we=(write), mem_addr, mem_wdata for cycle T+1; mem_en=0 when no grant.
REQ-020 SHALL form mem_addr as {front_bank, rd_addr} for reads and {~front_bank, wr_addr} for writes, bank sampled at grant cycle.
REQ-021 SHALL assert rd_valid in cycle T+2 for a read granted in T, rd_data = mem_rdata that cycle; throughput one access per cycle.
REQ-022 SHALL hold rd_data at last value when rd_valid low.
REQ-023 SHALL set swap_pending on swap_req; further swap_req while pending SHALL be ignored (one ack).
REQ-024 SHALL, in a cycle where frame_done is high and swap_pending (or swap_req) is high, toggle front_bank at that edge, clear swap_pending, and pulse swap_ack for exactly the next cycle.
REQ-025 SHALL leave reads already granted on the old bank unaffected by a swap (address captured at grant).
REQ-026 SHALL ignore frame_done with no swap pending.

Reset
REQ-027 SHALL, while rst high at a clock edge, clear: mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, swap_ack, swap_pending, front_bank, starvation counter; rd_gnt/wr_gnt SHALL be 0 during rst.
REQ-028 SHALL discard any in-flight read on reset; no rd_valid SHALL follow a mid-operation reset.

Configuration
REQ-029 SHALL, with LED_FB_STARVE_GUARD_EN defined, count consecutive read grants with wr_req high; on reaching STARVE_LIMIT, the next cycle with wr_req high SHALL grant write over read; counter clears on write grant or wr_req low.
REQ-030 SHALL, without LED_FB_STARVE_GUARD_EN, use strict read priority and contain no starvation counter.

Verification
REQ-031 Read only: rd_req=1, rd_addr=0x005, front_bank=0, RAM[0x005]=0xFF0000 -> rd_gnt T, mem_addr=0x005 T+1, rd_valid with rd_data=0xFF0000 at T+2.
REQ-032 Write only: wr_req=1, wr_addr=0x010, wr_data=0x00FF00 -> wr_gnt T, mem_we=1, mem_addr=0x810 at T+1.
REQ-033 Contention, guard on: rd_req and wr_req held high -> 8 read grants, 9th grant is write, then reads resume; guard off -> write never granted while rd_req high.
REQ-034 Swap: swap_req pulse, second swap_req, frame_done 3 cycles later -> front_bank 0->1 after frame_done edge, single swap_ack next cycle; later reads address 0x8xx.
REQ-035 Simultaneous swap_req and frame_done -> swap applied same edge, swap_ack next cycle.
REQ-036 Reset mid-read: rst asserted cycle after rd_gnt -> no rd_valid, all outputs 0, front_bank=0.
